// File: rtl/vector_multiply_add_issue_controller_if.sv
// Issue-controller bus: requester side, multiply-add unit side and response side.
// master = environment (requesters, unit, consumer); slave = the controller.
interface vector_multiply_add_issue_controller_if #(
    parameter int NUM_REQ = 2,
    parameter int VLEN    = 128,
    parameter int EXEC_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][EXEC_W-1:0] req_execution_vector;
    logic [NUM_REQ-1:0][VLEN-1:0]   req_vs2;
    logic [NUM_REQ-1:0][VLEN-1:0]   req_vs1;
    logic [NUM_REQ-1:0][VLEN-1:0]   req_vdd;

    logic [EXEC_W-1:0]              unit_execution_vector;
    logic [VLEN-1:0]                unit_vs2;
    logic [VLEN-1:0]                unit_vs1;
    logic [VLEN-1:0]                unit_vdd;
    logic [VLEN-1:0]                unit_vd;

    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [VLEN-1:0]                rsp_vd;
    logic [ID_W-1:0]                rsp_id;

    modport master (
        output req_valid, req_execution_vector, req_vs2, req_vs1, req_vdd,
        output unit_vd, rsp_ready,
        input  req_ready, unit_execution_vector, unit_vs2, unit_vs1, unit_vdd,
        input  rsp_valid, rsp_vd, rsp_id
    );

    modport slave (
        input  req_valid, req_execution_vector, req_vs2, req_vs1, req_vdd,
        input  unit_vd, rsp_ready,
        output req_ready, unit_execution_vector, unit_vs2, unit_vs1, unit_vdd,
        output rsp_valid, rsp_vd, rsp_id
    );
endinterface

// File: rtl/vector_multiply_add_issue_controller.sv
// Round-robin issue controller sharing one fixed-latency vector MAC unit, with credit-gated result FIFO.
// Optional VMA_ISSUE_PERF_EN adds perf_issue_count / perf_stall_count outputs.
module vector_multiply_add_issue_controller #(
    parameter int NUM_REQ    = 2,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int VLEN       = 128,
    parameter int EXEC_W     = 32
) (
    input  logic clock,
    input  logic reset_n,
    vector_multiply_add_issue_controller_if.slave bus
`ifdef VMA_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issue_count,
    output logic [31:0] perf_stall_count
`endif
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [VLEN-1:0] vd;
    } rsp_entry_t;

    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              grant;
    logic [ID_W-1:0]              arb_idx;
    logic                         found;
    logic                         issue_ok;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic [NUM_REQ-1:0]           rdy_vec;
    logic [CNT_W-1:0]             fifo_cnt;
    logic [CNT_W-1:0]             inflight_cnt;
    logic [LATENCY:1]             vld_pipe;
    logic [LATENCY:1][ID_W-1:0]   id_pipe;
    rsp_entry_t                   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;

    // Credit covers both buffered and in-flight results, so the FIFO can never overflow.
    assign issue_ok = ((CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(inflight_cnt)) < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        found   = 1'b0;
        grant   = '0;
        arb_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[arb_idx]) begin
                found = 1'b1;
                grant = arb_idx;
            end
        end
    end

    // reset_n gating keeps req_ready low while reset is asserted, even with valid requests.
    assign accept = found & issue_ok & reset_n;

    always_comb begin
        rdy_vec = '0;
        if (accept) rdy_vec[grant] = 1'b1;
    end

    assign bus.req_ready             = rdy_vec;
    assign bus.unit_execution_vector = accept ? bus.req_execution_vector[grant] : '0;
    assign bus.unit_vs2              = accept ? bus.req_vs2[grant] : '0;
    assign bus.unit_vs1              = accept ? bus.req_vs1[grant] : '0;
    assign bus.unit_vdd              = accept ? bus.req_vdd[grant] : '0;

    assign push          = vld_pipe[LATENCY];
    assign bus.rsp_valid = (fifo_cnt != '0);
    assign pop           = bus.rsp_ready & bus.rsp_valid;
    assign bus.rsp_vd    = mem[rd_ptr].vd;
    assign bus.rsp_id    = mem[rd_ptr].id;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            fifo_cnt     <= '0;
            inflight_cnt <= '0;
            vld_pipe     <= '0;
            id_pipe      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            inflight_cnt <= inflight_cnt + CNT_W'(accept) - CNT_W'(push);
            fifo_cnt     <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            // Tag pipeline mirrors the unit's fixed latency; the unit never stalls.
            vld_pipe[1] <= accept;
            id_pipe[1]  <= grant;
            for (int k = 2; k <= LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
            if (push) begin
                mem[wr_ptr] <= '{id: id_pipe[LATENCY], vd: bus.unit_vd};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef VMA_ISSUE_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issue_count <= '0;
            perf_stall_count <= '0;
        end else begin
            if (accept) perf_issue_count <= perf_issue_count + 32'd1;
            if (|bus.req_valid && !accept) perf_stall_count <= perf_stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vector_multiply_add_issue_controller.sv
// Directed bench: queue-based reference model of arbitration, credit and result ordering,
// plus a behavioural fixed-latency vmacc unit driving unit_vd.
module tb_vector_multiply_add_issue_controller;
    localparam int NR    = 2;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int VL    = 32;
    localparam int EW    = 8;
    localparam int ID_W  = 1;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    vector_multiply_add_issue_controller_if #(.NUM_REQ(NR), .VLEN(VL), .EXEC_W(EW)) bus ();

`ifdef VMA_ISSUE_PERF_EN
    logic [31:0] perf_issue_count;
    logic [31:0] perf_stall_count;
`endif

    vector_multiply_add_issue_controller #(
        .NUM_REQ(NR), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .VLEN(VL), .EXEC_W(EW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef VMA_ISSUE_PERF_EN
        ,
        .perf_issue_count (perf_issue_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    function automatic logic [VL-1:0] vmacc(input logic [VL-1:0] a, input logic [VL-1:0] b,
                                            input logic [VL-1:0] c);
        logic [VL-1:0] r;
        r = '0;
        for (int e = 0; e < VL / 8; e++) r[e*8 +: 8] = a[e*8 +: 8] * b[e*8 +: 8] + c[e*8 +: 8];
        return r;
    endfunction

    // Behavioural MAC unit: result appears LAT cycles after operands are driven.
    logic [VL-1:0] upipe [LAT];
    always @(posedge clock) begin
        upipe[0] <= vmacc(bus.unit_vs2, bus.unit_vs1, bus.unit_vdd);
        for (int k = 1; k < LAT; k++) upipe[k] <= upipe[k-1];
    end
    assign bus.unit_vd = upipe[LAT-1];

    typedef struct {
        int              due;
        logic [ID_W-1:0] id;
        logic [VL-1:0]   vd;
    } op_t;

    op_t inflt[$];
    op_t fifo_q[$];
    int  rr;
    int  cyc;
    int  n_vec;
    int  n_bad;
    int  acc_cyc[$];
    int  acc_id[$];
    int  pop_cyc[$];
    int  pop_id[$];
    logic [VL-1:0] pop_vd[$];
`ifdef VMA_ISSUE_PERF_EN
    logic [31:0] m_issue;
    logic [31:0] m_stall;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflt.delete();
        fifo_q.delete();
        rr = 0;
`ifdef VMA_ISSUE_PERF_EN
        m_issue = '0;
        m_stall = '0;
`endif
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); acc_id.delete();
        pop_cyc.delete(); pop_id.delete(); pop_vd.delete();
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_req_ready"}, bus.req_ready, 0);
        chk({nm, "_unit_exec"}, bus.unit_execution_vector, 0);
        chk({nm, "_unit_vs2"}, bus.unit_vs2, 0);
        chk({nm, "_unit_vs1"}, bus.unit_vs1, 0);
        chk({nm, "_unit_vdd"}, bus.unit_vdd, 0);
        chk({nm, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({nm, "_rsp_vd"}, bus.rsp_vd, 0);
        chk({nm, "_rsp_id"}, bus.rsp_id, 0);
`ifdef VMA_ISSUE_PERF_EN
        chk({nm, "_perf_issue"}, perf_issue_count, 0);
        chk({nm, "_perf_stall"}, perf_stall_count, 0);
`endif
    endtask

    // Entered at posedge+1 with inputs set; compares, advances the model, returns at next posedge+1.
    task automatic step();
        int              g;
        logic [NR-1:0]   exp_rdy;
        logic [VL-1:0]   e2, e1, ed;
        logic [EW-1:0]   ee;
        op_t             op;
        #2;
        g = -1;
        exp_rdy = '0;
        e2 = '0; e1 = '0; ed = '0; ee = '0;
        if (fifo_q.size() + inflt.size() < DEPTH)
            for (int k = 0; k < NR; k++)
                if (g < 0 && bus.req_valid[(rr + k) % NR]) g = (rr + k) % NR;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            e2 = bus.req_vs2[g]; e1 = bus.req_vs1[g]; ed = bus.req_vdd[g];
            ee = bus.req_execution_vector[g];
        end
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("unit_exec", bus.unit_execution_vector, ee);
        chk("unit_vs2", bus.unit_vs2, e2);
        chk("unit_vs1", bus.unit_vs1, e1);
        chk("unit_vdd", bus.unit_vdd, ed);
        chk("rsp_valid", bus.rsp_valid, fifo_q.size() > 0);
        if (fifo_q.size() > 0) begin
            chk("rsp_vd", bus.rsp_vd, fifo_q[0].vd);
            chk("rsp_id", bus.rsp_id, fifo_q[0].id);
        end
`ifdef VMA_ISSUE_PERF_EN
        chk("perf_issue", perf_issue_count, m_issue);
        chk("perf_stall", perf_stall_count, m_stall);
`endif
        for (int i = 0; i < NR; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                acc_cyc.push_back(cyc); acc_id.push_back(i);
            end
        if (bus.rsp_valid && bus.rsp_ready) begin
            pop_cyc.push_back(cyc); pop_id.push_back(int'(bus.rsp_id)); pop_vd.push_back(bus.rsp_vd);
        end
        if (bus.rsp_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (inflt.size() > 0 && inflt[0].due == cyc) fifo_q.push_back(inflt.pop_front());
`ifdef VMA_ISSUE_PERF_EN
        if (g >= 0) m_issue = m_issue + 32'd1;
        else if (|bus.req_valid) m_stall = m_stall + 32'd1;
`endif
        if (g >= 0) begin
            op.due = cyc + LAT;
            op.id  = ID_W'(g);
            op.vd  = vmacc(e2, e1, ed);
            inflt.push_back(op);
            rr = (g + 1) % NR;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req_vs2[i] = {4{a}};
        bus.req_vs1[i] = {4{b}};
        bus.req_vdd[i] = {4{c}};
        bus.req_execution_vector[i] = EW'(8'h10 + i);
    endtask

    task automatic set_idle();
        bus.req_valid = '0;
        for (int i = 0; i < NR; i++) set_op(i, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_reset("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        n_vec = 0; n_bad = 0; cyc = 0;
        reset_n = 1'b0;
        set_idle();
        bus.req_valid = 2'b01;   // valid during reset must not be granted
        bus.rsp_ready = 1'b1;
        model_reset();
        clear_logs();
        repeat (2) @(posedge clock);
        #1;
        chk_reset("por");
        reset_n = 1'b1;
        set_idle();

        // 1: single vmacc op, 3*4+5 = 17 per element
        set_op(0, 8'd3, 8'd4, 8'd5);
        bus.req_valid = 2'b01;
        #1;
        chk("t1_ready", bus.req_ready, 2'b01);
        step();
        set_idle();
        repeat (LAT) step();
        chk("t1_rsp_valid", bus.rsp_valid, 1);
        chk("t1_rsp_vd", bus.rsp_vd, 32'h1111_1111);
        chk("t1_rsp_id", bus.rsp_id, 0);
        repeat (3) step();

        // 2: round robin from pointer 0
        do_reset();
        clear_logs();
        for (int k = 0; k < 6; k++) begin
            set_op(0, 8'd1, 8'd2, 8'(k));
            set_op(1, 8'd2, 8'd3, 8'(k + 16));
            bus.req_valid = 2'b11;
            step();
        end
        set_idle();
        repeat (6) step();
        chk("t2_acc_n", acc_id.size(), 6);
        chk("t2_rsp_n", pop_id.size(), 6);
        for (int k = 0; k < 6 && k < acc_id.size() && k < pop_id.size(); k++) begin
            chk("t2_grant", acc_id[k], k % 2);
            chk("t2_rsp_id", pop_id[k], k % 2);
        end

        // 3: backpressure fills credit, release resumes one cycle after first pop
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_op(0, 8'd1, 8'd1, 8'(k + 1));
            bus.req_valid = 2'b01;
            step();
        end
        chk("t3_acc_n", acc_cyc.size(), 4);
        chk("t3_stalled", bus.req_ready, 0);
        b = cyc;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_op(0, 8'd1, 8'd1, 8'(k + 9));
            bus.req_valid = 2'b01;
            step();
        end
        set_idle();
        repeat (8) step();
        if (pop_cyc.size() >= 4 && acc_cyc.size() >= 5) begin
            chk("t3_first_pop", pop_cyc[0], b);
            chk("t3_resume", acc_cyc[4], b + 1);
            for (int k = 0; k < 4; k++) chk("t3_order_vd", pop_vd[k], {4{8'(k + 2)}});
        end else chk("t3_counts", pop_cyc.size(), 12);

        // 4: simultaneous push and pop with three buffered
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_op(0, 8'd2, 8'd2, 8'(k));
            bus.req_valid = 2'b01;
            step();
        end
        set_idle();
        step();
        bus.rsp_ready = 1'b1;
        step();
        chk("t4_still_valid", bus.rsp_valid, 1);
        repeat (8) step();
        chk("t4_acc_n", acc_cyc.size(), 4);
        chk("t4_rsp_n", pop_vd.size(), 4);
        for (int k = 0; k < 4 && k < pop_vd.size(); k++) chk("t4_vd", pop_vd[k], {4{8'(k + 4)}});

        // 5: reset with two in flight and one buffered
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_op(0, 8'd5, 8'd5, 8'(k));
            bus.req_valid = 2'b01;
            step();
        end
        chk("t5_buffered", bus.rsp_valid, 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_reset("t5_async");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        set_idle();
        bus.rsp_ready = 1'b1;
        clear_logs();
        repeat (10) step();
        chk("t5_no_rsp", pop_vd.size(), 0);

        // 6: idle keeps pointer; grant 0 leaves pointer at 1
        set_op(0, 8'd1, 8'd1, 8'd1);
        bus.req_valid = 2'b01;
        step();
        set_idle();
        repeat (10) step();
        bus.req_valid = 2'b11;
        #1;
        chk("t6_ptr_hold", bus.req_ready, 2'b10);
        step();
        set_idle();
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
